// File: rtl/am_profile_seq.sv
`default_nettype none
// ============================================================================
// Module      : am_profile_seq
// Description : Four-slot AM profile sequencer. Each slot holds a carrier
//               phase increment, a modulation depth and a dwell time. Once
//               started, the slots are played in order. Every slot change is
//               aligned to a rising edge of the carrier DDS MSB, so the
//               carrier never switches frequency mid-cycle.
//               Optional macro AM_SEQ_LOOP_EN: wrap from the last slot back
//               to slot 0 and keep running until stop. When the macro is not
//               defined, the sequencer halts after the last slot.
// Revision    : 1.0 - initial release
// ============================================================================
module am_profile_seq #(
    parameter int NPROF   = 4,
    parameter int DWELL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(NPROF)-1:0] cfg_addr,
    input  logic [31:0]              cfg_freq,
    input  logic [11:0]              cfg_ma,
    input  logic [DWELL_W-1:0]       cfg_dwell,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     carrier_msb,
    output logic [31:0]              freq_word,
    output logic [11:0]              ma_out,
    output logic [$clog2(NPROF)-1:0] prof_idx,
    output logic                     upd_strobe,
    output logic                     busy,
    output logic                     cfg_err
);

    localparam int                 C_IDX_W   = $clog2(NPROF);
    localparam logic [11:0]        C_MA_MIN  = 12'd100;
    localparam logic [11:0]        C_MA_MAX  = 12'd1000;
    localparam logic [C_IDX_W-1:0] C_LAST    = C_IDX_W'(NPROF - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_WAIT = 2'd1;
    localparam logic [1:0] C_ST_RUN  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_msb;
    logic               w_sync;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               w_start;
    logic               w_load;
    logic               w_run_tick;
    logic               w_cfg_ok;
    logic               w_cfg_rej;
    logic [11:0]        w_ma_clamp;
    logic [DWELL_W-1:0] w_dwell_wr;
    logic [C_IDX_W-1:0] w_idx_next;

    logic [31:0]        r_tbl_freq  [NPROF];
    logic [11:0]        r_tbl_ma    [NPROF];
    logic [DWELL_W-1:0] r_tbl_dwell [NPROF];

    // A sync event is a rising edge of the carrier MSB seen against the previous cycle.
    assign w_sync = ~r_msb & carrier_msb;

    // A zero dwell would never expire, so it is stored as the shortest legal dwell.
    assign w_dwell_wr = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;

`ifdef AM_SEQ_LOOP_EN
    assign w_idx_next = (prof_idx == C_LAST) ? '0 : prof_idx + C_IDX_W'(1);
`else
    assign w_idx_next = (prof_idx == C_LAST) ? prof_idx : prof_idx + C_IDX_W'(1);
`endif

    // Keep the stored modulation depth inside the 10%..100% range.
    always_comb begin
        w_ma_clamp = cfg_ma;
        if (cfg_ma < C_MA_MIN) begin
            w_ma_clamp = C_MA_MIN;
        end else if (cfg_ma > C_MA_MAX) begin
            w_ma_clamp = C_MA_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; stop overrides every other request.
    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = C_ST_IDLE;
        end else begin
            case (r_state)
                C_ST_IDLE: if (start)  w_next_state = C_ST_WAIT;
                C_ST_WAIT: if (w_sync) w_next_state = C_ST_RUN;
                C_ST_RUN: begin
                    if (r_dwell_cnt == DWELL_W'(1)) begin
`ifdef AM_SEQ_LOOP_EN
                        w_next_state = C_ST_WAIT;
`else
                        w_next_state = (prof_idx == C_LAST) ? C_ST_IDLE : C_ST_WAIT;
`endif
                    end
                end
                default: w_next_state = C_ST_IDLE;
            endcase
        end
    end

    // State-decoded controls for the datapath and the busy flag.
    always_comb begin
        busy       = (r_state != C_ST_IDLE);
        w_start    = (r_state == C_ST_IDLE) && start && !stop;
        w_load     = (r_state == C_ST_WAIT) && w_sync && !stop;
        w_run_tick = (r_state == C_ST_RUN) && !stop;
        w_cfg_ok   = cfg_we && (r_state == C_ST_IDLE);
        w_cfg_rej  = cfg_we && (r_state != C_ST_IDLE);
    end

    // Profile table; writes are only honoured while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPROF; i++) begin
                r_tbl_freq[i]  <= '0;
                r_tbl_ma[i]    <= C_MA_MAX;
                r_tbl_dwell[i] <= DWELL_W'(1);
            end
        end else begin
            for (int i = 0; i < NPROF; i++) begin
                if (w_cfg_ok && (cfg_addr == C_IDX_W'(i))) begin
                    r_tbl_freq[i]  <= cfg_freq;
                    r_tbl_ma[i]    <= w_ma_clamp;
                    r_tbl_dwell[i] <= w_dwell_wr;
                end
            end
        end
    end

    // Output registers, dwell counter and carrier-MSB history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_word   <= '0;
            ma_out      <= C_MA_MAX;
            prof_idx    <= '0;
            upd_strobe  <= 1'b0;
            cfg_err     <= 1'b0;
            r_dwell_cnt <= '0;
            r_msb       <= 1'b0;
        end else begin
            r_msb      <= carrier_msb;
            upd_strobe <= w_load;
            cfg_err    <= w_cfg_rej;
            if (w_start) begin
                prof_idx <= '0;
            end
            if (w_load) begin
                freq_word   <= r_tbl_freq[prof_idx];
                ma_out      <= r_tbl_ma[prof_idx];
                r_dwell_cnt <= r_tbl_dwell[prof_idx];
            end else if (w_run_tick) begin
                r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                if (r_dwell_cnt == DWELL_W'(1)) begin
                    prof_idx <= w_idx_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_am_profile_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_am_profile_seq
// Description : Scoreboard bench for am_profile_seq. Stimulus pushes the
//               expected slot loads into a queue; a monitor pops and checks
//               them on every upd_strobe, including carrier alignment and
//               dwell length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_am_profile_seq;

    localparam int NPROF   = 4;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [31:0]        cfg_freq = '0;
    logic [11:0]        cfg_ma = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               carrier_msb = 1'b0;
    logic [31:0]        freq_word;
    logic [11:0]        ma_out;
    logic [1:0]         prof_idx;
    logic               upd_strobe;
    logic               busy;
    logic               cfg_err;

    always #5 clk = ~clk;

    am_profile_seq #(.NPROF(NPROF), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .cfg_ma(cfg_ma), .cfg_dwell(cfg_dwell),
        .start(start), .stop(stop), .carrier_msb(carrier_msb),
        .freq_word(freq_word), .ma_out(ma_out), .prof_idx(prof_idx),
        .upd_strobe(upd_strobe), .busy(busy), .cfg_err(cfg_err)
    );

    typedef struct {
        logic [31:0] freq;
        logic [11:0] ma;
        logic [1:0]  idx;
        int          dwell;   // 0: do not measure the run length
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     mon_n;
    int     checks = 0;
    int     errors = 0;
    int     n_str = 0;
    longint cyc = 0;
    longint rise_cyc = -100;
    int     car_half = 4;
    int     car_cnt = 0;
    bit     car_auto = 1'b0;
    bit     car_man = 1'b0;

    logic [31:0] m_freq  [NPROF];
    logic [11:0] m_ma    [NPROF];
    int          m_dwell [NPROF];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_ma(input int v);
        if (v < 100) return 100;
        if (v > 1000) return 1000;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NPROF; i++) begin
            m_freq[i]  = '0;
            m_ma[i]    = 12'd1000;
            m_dwell[i] = 1;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Carrier MSB: free-running square wave or manually driven level.
    always begin
        @(posedge clk);
        #1;
        if (car_auto) begin
            car_cnt++;
            if (car_cnt >= car_half) begin
                car_cnt = 0;
                carrier_msb = ~carrier_msb;
                if (carrier_msb) rise_cyc = cyc;
            end
        end else begin
            if (car_man && !carrier_msb) rise_cyc = cyc;
            carrier_msb = car_man;
        end
    end

    // Monitor: every strobe must match the next expected slot load.
    always begin
        @(negedge clk);
        if (rst && upd_strobe) begin
            n_str++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_unexpected: got strobe at idx %0d, required none", prof_idx);
            end else begin
                mon_e = q.pop_front();
                chk("strobe_freq", freq_word, mon_e.freq);
                chk("strobe_ma", ma_out, mon_e.ma);
                chk("strobe_idx", prof_idx, mon_e.idx);
                chk("strobe_sync_align", cyc, rise_cyc + 1);
                if (mon_e.dwell != 0) begin
                    mon_n = 0;
                    do begin
                        @(negedge clk);
                        mon_n++;
                        if (mon_n == 1) chk("strobe_width", upd_strobe, 0);
                    end while (busy && prof_idx == mon_e.idx && mon_n < 5000);
                    chk("run_length", mon_n, mon_e.dwell);
                    chk("hold_freq", freq_word, mon_e.freq);
                    chk("hold_ma", ma_out, mon_e.ma);
                end
            end
        end
    end

    task automatic write_slot(input int a, input logic [31:0] f, input int m, input int d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = a[1:0];
        cfg_freq  = f;
        cfg_ma    = m[11:0];
        cfg_dwell = d[DWELL_W-1:0];
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err_idle_write", cfg_err, 0);
        m_freq[a]  = f;
        m_ma[a]    = 12'(clamp_ma(m));
        m_dwell[a] = (d == 0) ? 1 : d;
    endtask

    task automatic wait_strobes(input int target);
        int budget;
        budget = 0;
        while (n_str < target && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
    endtask

    // Play the whole table once; optionally poke a write in while running.
    task automatic run_seq(input int half, input bit with_err);
        int base;
        int target;
        int budget;
        car_half = half;
        car_auto = 1'b1;
        base = n_str;
        for (int k = 0; k < NPROF; k++)
            q.push_back('{freq: m_freq[k], ma: m_ma[k], idx: k[1:0], dwell: m_dwell[k]});
`ifdef AM_SEQ_LOOP_EN
        q.push_back('{freq: m_freq[0], ma: m_ma[0], idx: 2'd0, dwell: 0});
        target = base + NPROF + 1;
`else
        target = base + NPROF;
`endif
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (with_err) begin
            wait_strobes(base + 1);
            cfg_we = 1'b1; cfg_addr = 2'd2; cfg_freq = 32'hDEADBEEF; cfg_ma = 12'd5; cfg_dwell = 16'd7;
            @(negedge clk);
            cfg_we = 1'b0;
            chk("cfg_err_pulse", cfg_err, 1);
            @(negedge clk);
            chk("cfg_err_width", cfg_err, 0);
        end
        wait_strobes(target);
        chk("strobe_count", n_str - base, target - base);
`ifdef AM_SEQ_LOOP_EN
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`endif
        budget = 0;
        while (busy && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        chk("busy_after_run", busy, 0);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        model_reset();
        // Reset values while held and after release.
        repeat (3) @(negedge clk);
        chk("rst_freq", freq_word, 0);
        chk("rst_ma", ma_out, 1000);
        chk("rst_idx", prof_idx, 0);
        chk("rst_strobe", upd_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Reset table contents: freq 0, ma 1000, dwell 1.
        run_seq(4, 1'b0);

        // start and stop together in IDLE: stay idle.
        car_auto = 1'b0;
        car_man  = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("prio_idle_busy", busy, 0);
        @(negedge clk);
        chk("prio_idle_busy2", busy, 0);

        // stop coinciding with a sync event in WAIT_SYNC: idle, no load.
        base = n_str;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        car_man = 1'b1;
        chk("prio_wait_busy", busy, 1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("prio_sync_busy", busy, 0);
        chk("prio_sync_strobe", upd_strobe, 0);
        repeat (2) @(negedge clk);
        chk("prio_sync_no_load", n_str, base);
        car_man = 1'b0;
        repeat (2) @(negedge clk);

        // Clamp: ma 50 -> 100, dwell 0 -> 1.
        write_slot(0, 32'h0000_1234, 50, 0);
        run_seq(3, 1'b0);

        // Reference sequence with a rejected write during RUN.
        for (int k = 0; k < NPROF; k++)
            write_slot(k, 32'h0147AE14 + k, 250 * (k + 1), 10);
        run_seq(4, 1'b1);

        // Randomized tables and carrier periods.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NPROF; k++)
                write_slot(k, $urandom, int'($urandom_range(0, 1500)), int'($urandom_range(0, 12)));
            run_seq(int'($urandom_range(2, 5)), 1'b0);
        end

        // Reset asserted mid-RUN.
        for (int k = 0; k < NPROF; k++)
            write_slot(k, 32'hA5A5_0000 + k, 600, 9);
        car_half = 3;
        car_auto = 1'b1;
        base = n_str;
        for (int k = 0; k < NPROF; k++)
            q.push_back('{freq: m_freq[k], ma: m_ma[k], idx: k[1:0], dwell: 0});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobes(base + 1);
        chk("midrun_busy", busy, 1);
        #3 rst = 1'b0;
        #1;
        chk("midrun_rst_freq", freq_word, 0);
        chk("midrun_rst_ma", ma_out, 1000);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_strobe", upd_strobe, 0);
        chk("midrun_rst_idx", prof_idx, 0);
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Table must be back to its reset contents.
        run_seq(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/am_profile_seq.md
AM_PROFILE_SEQ -- requirements
Module: am_profile_seq

Interface
REQ-001 Parameter NPROF, 4: number of profile slots; index width is 2 bits.
REQ-002 Parameter DWELL_W, 16: dwell counter width.
REQ-003 clk  in  1  system clock; all logic sits on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cfg_we  in  1  profile write strobe.
REQ-006 cfg_addr  in  2  profile slot to write.
REQ-007 cfg_freq  in  32  carrier DDS phase-increment word for the slot.
REQ-008 cfg_ma  in  12  modulation depth for the slot, 100..1000 meaning 10%..100%.
REQ-009 cfg_dwell  in  DWELL_W  slot dwell time in clk cycles.
REQ-010 start  in  1  level-sampled run request.
REQ-011 stop  in  1  level-sampled abort request.
REQ-012 carrier_msb  in  1  MSB of the carrier DDS phase accumulator.
REQ-013 freq_word  out  32  phase increment driven to the carrier DDS.
REQ-014 ma_out  out  12  modulation depth driven to the AM multiplier.
REQ-015 prof_idx  out  2  index of the active profile.
REQ-016 upd_strobe  out  1  one-cycle pulse on every freq_word/ma_out load.
REQ-017 busy  out  1  high in WAIT_SYNC and RUN.
REQ-018 cfg_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-019 The block SHALL hold NPROF profile registers {freq, ma, dwell}; a write SHALL be accepted only in IDLE and SHALL take effect on the next edge.
REQ-020 When cfg_we is high outside IDLE, the block SHALL leave the table unchanged and pulse cfg_err on the next cycle.
REQ-021 On write, ma SHALL be clamped: values below 100 store 100, values above 1000 store 1000. dwell 0 SHALL be stored as 1.
REQ-022 The FSM SHALL have three states: IDLE, WAIT_SYNC and RUN.
REQ-023 IDLE to WAIT_SYNC: on start=1 and stop=0; prof_idx SHALL be set to 0.
REQ-024 The block SHALL register carrier_msb once. A sync event is a cycle in which the registered value is 0 and the current value is 1.
REQ-025 WAIT_SYNC to RUN: on a sync event. On that edge, freq_word/ma_out SHALL load slot prof_idx, upd_strobe SHALL pulse for 1 cycle, and the dwell counter SHALL load the slot's dwell.
REQ-026 In RUN, the dwell counter SHALL decrement each cycle. At count 1, the FSM SHALL advance prof_idx and return to WAIT_SYNC, so RUN lasts exactly dwell cycles.
REQ-027 Wrap behaviour after the last slot (prof_idx=3) is defined in Configuration.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge. freq_word, ma_out and prof_idx SHALL hold their values. stop SHALL take priority over start and over sync events in the same cycle.
REQ-029 freq_word and ma_out SHALL change only on upd_strobe edges, never mid-dwell.
REQ-030 start is ignored while busy.

Reset
REQ-031 Reset values, applied asynchronously:
- FSM: IDLE.
- freq_word=0, ma_out=1000, prof_idx=0, upd_strobe=0, busy=0, cfg_err=0.
- All table entries: freq=0, ma=1000, dwell=1.
- Dwell counter=0; registered carrier_msb=0.
REQ-032 Reset asserted mid-run SHALL return all of the above within the reset assertion.

Configuration
REQ-033 Macro AM_SEQ_LOOP_EN selects the behaviour after the last slot's dwell expires.
REQ-034 With AM_SEQ_LOOP_EN defined: prof_idx SHALL wrap to 0, the FSM SHALL enter WAIT_SYNC, and sequencing SHALL continue until stop.
REQ-035 Without AM_SEQ_LOOP_EN: the FSM SHALL enter IDLE, busy SHALL drop on the next edge, and outputs SHALL hold the last slot's values.

Verification
REQ-036 Reset: assert rst=0 mid-RUN -> freq_word=0, ma_out=1000, busy=0, upd_strobe=0.
REQ-037 Clamp: write slot0 ma=50, dwell=0 then run -> ma_out=100 and RUN lasts 1 cycle.
REQ-038 Sequencing: program slots 0..3 with freq=0x0147AE14+k, ma=250*(k+1), dwell=10; start; toggle carrier_msb every 4 cycles -> 4 upd_strobe pulses, each aligned to a rising carrier_msb edge, each RUN lasting 10 cycles, prof_idx 0,1,2,3.
- With AM_SEQ_LOOP_EN: the 5th strobe loads slot0.
- Without it: busy=0 after slot3.
REQ-039 Write while busy: cfg_we with addr=2 during RUN -> cfg_err pulses 1 cycle and a later read-out of slot2 is unchanged.
REQ-040 Priority: start=1 and stop=1 in IDLE -> stays IDLE. stop coinciding with a sync event in WAIT_SYNC -> IDLE, no upd_strobe.
